// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit/VC sizing for the router output channel plus
// the router input channel types that sit alongside it.
package noc_pkg;

  // Output channel sizing and VC index constants
  localparam int DATA_W = 64;
  localparam int DEPTH  = 2;
  localparam int NUM_VC = 2;
  localparam int VC0    = 0;
  localparam int VC1    = 1;

  // Router input channel definitions
  localparam int IN_DEPTH = 4;

  typedef enum logic [2:0] {
    port_local = 3'd0,
    port_north = 3'd1,
    port_east  = 3'd2,
    port_south = 3'd3,
    port_west  = 3'd4
  } port_t;

  typedef struct packed {
    logic  vc;
    port_t dest;
  } in_route_t;

endpackage

// File: rtl/output_vc_fifo.sv
// One virtual-channel FIFO: DEPTH entries, wrapping pointers and an occupancy
// count. The caller guarantees push only when not full and pop only when not
// empty.
module output_vc_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count
);
  import noc_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  // Pointer advance with explicit wrap from DEPTH-1 back to 0
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy update; reset wins over any same-cycle push/pop
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Flit storage; contents are meaningless once count is cleared
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/router_output_channel.sv
// Router output channel: two VC FIFOs steered by the global even/odd polarity.
// Only the VC selected by polarity is written or read in a given cycle, and
// popped flits leave through a one-cycle output register.
//
// Handshake: a push happens when wr_en && wr_ready at the clock edge (wr_ready
// is combinational from the registered count of the selected VC, judged before
// any same-cycle pop); a pop happens when out_ready && selected VC non-empty,
// and shows up as out_send/out_data in the following cycle. A rejected flit is
// kept by the switch.
module router_output_channel #(
  parameter int DATA_W = noc_pkg::DATA_W,
  parameter int DEPTH  = noc_pkg::DEPTH   // power of two, at least 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              out_ready,
  output logic              out_send,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        vc_full,
  output logic [1:0]        vc_empty
);
  import noc_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]  count [NUM_VC];
  logic [DATA_W-1:0] head  [NUM_VC];
  logic [NUM_VC-1:0] push;
  logic [NUM_VC-1:0] pop;
  logic              do_pop;
  logic [DATA_W-1:0] sel_head;

  // Polarity steering of push/pop and per-VC status flags
  always_comb begin
    push     = '0;
    pop      = '0;
    wr_ready = (count[polarity] < CNT_W'(DEPTH));
    do_pop   = out_ready && (count[polarity] != '0);
    sel_head = head[polarity];
    push[polarity] = wr_en && wr_ready;
    pop[polarity]  = do_pop;
    for (int n = 0; n < NUM_VC; n++) begin
      vc_full[n]  = (count[n] == CNT_W'(DEPTH));
      vc_empty[n] = (count[n] == '0);
    end
  end

  output_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_vc0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push[VC0]),
    .push_data (wr_data),
    .pop       (pop[VC0]),
    .head      (head[VC0]),
    .count     (count[VC0])
  );

  output_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_vc1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push[VC1]),
    .push_data (wr_data),
    .pop       (pop[VC1]),
    .head      (head[VC1]),
    .count     (count[VC1])
  );

  // Output register: popped head next cycle, zeros otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      out_send <= 1'b0;
      out_data <= '0;
    end else begin
      out_send <= do_pop;
      out_data <= do_pop ? sel_head : '0;
    end
  end

endmodule

// File: tb/tb_router_output_channel.sv
// Bench for router_output_channel: directed scenarios followed by random
// traffic, all checked against a queue-based model of the two VCs.
module tb_router_output_channel;
  localparam int W     = 64;
  localparam int DEPTH = 2;

  logic          clk;
  logic          reset;
  logic          polarity;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          wr_ready;
  logic          out_ready;
  logic          out_send;
  logic [W-1:0]  out_data;
  logic [1:0]    vc_full;
  logic [1:0]    vc_empty;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: one queue per VC plus the expected registered output
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic         exp_send;
  logic [W-1:0] exp_data;

  router_output_channel #(.DATA_W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .polarity  (polarity),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .out_ready (out_ready),
    .out_send  (out_send),
    .out_data  (out_data),
    .vc_full   (vc_full),
    .vc_empty  (vc_empty)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check pre-edge status, advance the model,
  // clock, then check the registered output. Entered and left at posedge+1.
  task automatic cycle(input logic pol, input logic we, input logic [W-1:0] wd,
                       input logic ordy, input logic rst);
    int           sz;
    logic         do_pop;
    logic         do_push;
    logic [W-1:0] hd;
    polarity  = pol;
    wr_en     = we;
    wr_data   = wd;
    out_ready = ordy;
    reset     = rst;
    #1;
    sz = pol ? exp_q1.size() : exp_q0.size();
    check("wr_ready", W'(wr_ready), W'(sz < DEPTH));
    check("vc_full",  W'(vc_full),  W'({exp_q1.size() == DEPTH, exp_q0.size() == DEPTH}));
    check("vc_empty", W'(vc_empty), W'({exp_q1.size() == 0, exp_q0.size() == 0}));
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      exp_send = 1'b0;
      exp_data = '0;
    end else begin
      do_pop  = ordy && (sz > 0);
      do_push = we && (sz < DEPTH);
      hd = '0;
      if (do_pop) hd = pol ? exp_q1.pop_front() : exp_q0.pop_front();
      if (do_push) begin
        if (pol) exp_q1.push_back(wd);
        else     exp_q0.push_back(wd);
      end
      exp_send = do_pop;
      exp_data = do_pop ? hd : '0;
    end
    @(posedge clk);
    #1;
    check("out_send", W'(out_send), W'(exp_send));
    check("out_data", out_data, exp_data);
  endtask

  initial begin
    logic [W-1:0] wrap_flits [5];
    logic [W-1:0] rd;

    // Reset for two cycles, then release
    reset = 1'b1; polarity = 1'b0; wr_en = 1'b0; wr_data = '0; out_ready = 1'b0;
    exp_send = 1'b0; exp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_out_send", W'(out_send), '0);
    check("rst_out_data", out_data, '0);
    check("rst_vc_empty", W'(vc_empty), W'(2'b11));
    check("rst_vc_full",  W'(vc_full),  W'(2'b00));
    check("rst_wr_ready", W'(wr_ready), W'(1'b1));
    @(posedge clk); #1;

    // Single flit: A5 written on polarity 0, polarity toggling
    cycle(1'b0, 1'b1, 64'hA5, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    check("single_early", W'(out_send), '0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("single_send", W'(out_send), W'(1'b1));
    check("single_data", out_data, 64'hA5);
    check("single_empty", W'(vc_empty), W'(2'b11));

    // Fill VC1 with out_ready low, third write dropped
    cycle(1'b1, 1'b1, 64'h1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 64'h2, 1'b0, 1'b0);
    check("fill_full", W'(vc_full), W'(2'b10));
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    polarity = 1'b1; #1;
    check("fill_wr_ready", W'(wr_ready), '0);
    @(posedge clk); #1;
    cycle(1'b1, 1'b1, 64'h3, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    check("fill_first", out_data, 64'h1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    check("fill_second", out_data, 64'h2);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    check("fill_no_third", W'(out_send), '0);

    // Simultaneous push and pop on VC0
    cycle(1'b0, 1'b1, 64'hA, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 64'hB, 1'b1, 1'b0);
    check("pushpop_data", out_data, 64'hA);
    check("pushpop_count", W'(vc_empty), W'(2'b10));
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("pushpop_next", out_data, 64'hB);

    // Wrap-around with a zero flit
    wrap_flits = '{64'h11, 64'h0, 64'h22, 64'h33, 64'h44};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, wrap_flits[i], 1'b1, 1'b0);
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    end
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("wrap_last", out_data, 64'h44);

    // Reset mid-operation with both VCs full
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 64'h100 + 64'(i), 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 64'h200 + 64'(i), 1'b0, 1'b0);
    end
    check("mid_full", W'(vc_full), W'(2'b11));
    cycle(1'b0, 1'b1, 64'h999, 1'b1, 1'b1);
    check("mid_empty", W'(vc_empty), W'(2'b11));
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("mid_lost", W'(out_send), '0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rd = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rd = '0;
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_output_channel.md
ROUTER_OUTPUT_CHANNEL -- requirements
Module: router_output_channel

Interface
REQ-001 The block SHALL take parameter DATA_W, default 64, which sets the flit width in bits.
REQ-002 The block SHALL take parameter DEPTH, default 2, which sets the entries per virtual channel (VC); it SHALL be a power of two and at least 2.
REQ-003 clk  input  1  Clock; all state updates on the rising edge.
REQ-004 reset  input  1  Synchronous, active-high reset.
REQ-005 polarity  input  1  Global even/odd cycle phase: 0 selects VC0, 1 selects VC1.
REQ-006 wr_en  input  1  The switch presents a flit this cycle.
REQ-007 wr_data  input  DATA_W  Flit from the switch.
REQ-008 wr_ready  output  1  The VC selected by the current polarity can accept a flit.
REQ-009 out_ready  input  1  The downstream router input channel can accept a flit.
REQ-010 out_send  output  1  A flit is valid on out_data this cycle.
REQ-011 out_data  output  DATA_W  Flit to the downstream link; 0 when out_send=0.
REQ-012 vc_full  output  2  Per-VC full flags; bit n is VCn.
REQ-013 vc_empty  output  2  Per-VC empty flags; bit n is VCn.

Function
REQ-014 Each VC SHALL be a FIFO of DEPTH entries, with a read pointer, a write pointer and an occupancy count of clog2(DEPTH)+1 bits.
REQ-015 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-016 wr_ready SHALL be combinational and SHALL equal (count[polarity] < DEPTH).
REQ-017 Write rule: wr_en=1 and wr_ready=1 SHALL push wr_data into VC[polarity] at the clock edge.
REQ-018 wr_en=1 with wr_ready=0 SHALL drop the flit and leave the FIFO state unchanged; the switch retains the flit.
REQ-019 Read rule: out_ready=1 and VC[polarity] non-empty SHALL pop the head of VC[polarity] at the clock edge.
REQ-020 On a pop, out_send SHALL be 1 and out_data SHALL be the head flit in the following cycle (1-cycle registered latency).
REQ-021 In any cycle with no pop, out_send and out_data SHALL both be 0 in the following cycle.
REQ-022 The block SHALL NOT pop from, or write to, the VC not selected by polarity.
REQ-023 A push and a pop to the same VC in one cycle SHALL both occur, leaving the count unchanged.
REQ-024 Full decision: a push SHALL be judged against the pre-pop count, with no bypass; a flit written while full SHALL be rejected even if a pop occurs in the same cycle.
REQ-025 An empty VC with out_ready=1 SHALL produce no pop, out_send=0, and no pointer change.
REQ-026 A flit SHALL NOT be forwarded in the cycle it is written; minimum write-to-out_send latency is 2 cycles (write edge, then pop edge on the next matching polarity).
REQ-027 Flits within one VC SHALL leave in write order; no ordering is required between VCs.
REQ-028 vc_full[n] SHALL be (count[n]==DEPTH) and vc_empty[n] SHALL be (count[n]==0), both derived from registered counts.
REQ-029 A flit whose value is all zeros SHALL be transferred like any other flit; validity is carried only by out_send.

Reset
REQ-030 While reset=1 at a clock edge, all pointers and counts SHALL clear to 0, out_send SHALL be 0, out_data SHALL be 0, and stored flits SHALL be discarded.
REQ-031 After reset, vc_empty SHALL be 2'b11, vc_full SHALL be 2'b00, and wr_ready SHALL be 1.
REQ-032 A reset asserted mid-operation SHALL take precedence over any same-cycle push or pop.

Structure
REQ-033 DATA_W, DEPTH and the VC index constants (VC0=0, VC1=1) SHALL live in the shared noc package, alongside the router input channel definitions.
REQ-034 The per-VC FIFO SHALL be a sub-module named output_vc_fifo, instantiated twice.
REQ-035 The polarity-based write/read steering and the output register SHALL remain in the top level.

Verification
REQ-036 Reset check: reset for 2 cycles, then release -> out_send=0, out_data=0, vc_empty=2'b11, wr_ready=1.
REQ-037 Single flit: write 64'hA5 with polarity=0, toggle polarity each cycle, out_ready=1 -> out_send=1 with out_data=64'hA5 exactly 2 cycles after the write edge; vc_empty returns to 2'b11.
REQ-038 Fill to full: out_ready=0, write 64'h1 and 64'h2 into VC1 on polarity=1 cycles -> vc_full[1]=1 and wr_ready=0 when polarity=1; a third write of 64'h3 is dropped; with out_ready=1 the outputs are 64'h1 then 64'h2 only.
REQ-039 Simultaneous push and pop: with VC0 holding one flit, push 64'hB and pop in the same polarity=0 cycle -> count stays 1 and the next VC0 output is 64'hB.
REQ-040 Wrap and zero flit: push and pop 5 flits, including 64'h0, through VC0 (DEPTH=2) -> all 5 emerge in order, and the 64'h0 flit appears with out_send=1.
REQ-041 Reset mid-operation: both VCs full, then reset asserted for 1 cycle -> all flits are lost, out_send=0 from the next cycle, and vc_empty=2'b11.
